// File: rtl/screen_pkg.sv
// Shared constants for the LED-matrix frame loader: geometry, register map,
// CTRL bit positions, FSM encodings and the fixed gamma curve.
// Imported by screen_fifo and screen_frame_loader.
package screen_pkg;

  localparam int NUM_PIXELS      = 4096;  // 64x64
  localparam int TOTAL_BIT_DEPTH = 12;    // {R[11:8],G[7:4],B[3:0]}
  localparam int FIFO_DEPTH      = 16;
  localparam int COUNT_W         = 13;    // must hold NUM_PIXELS itself

  // Bus register offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_ABORT = 2;

  // IDLE must be 0 so STATUS reads 0x04 straight out of reset
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_GAP    = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  typedef logic [TOTAL_BIT_DEPTH-1:0] pixel_t;

  // Gamma curve, entry i at bits [4*i +: 4]:
  // {0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15}
  localparam logic [63:0] GAMMA_TABLE = {
    4'd15, 4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3,
    4'd2,  4'd2,  4'd1,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [3:0] gamma_nib(input logic [3:0] nib);
    return GAMMA_TABLE[{nib, 2'b00} +: 4];
  endfunction

  function automatic pixel_t gamma_map(input pixel_t px);
    return {gamma_nib(px[11:8]), gamma_nib(px[7:4]), gamma_nib(px[3:0])};
  endfunction

endpackage

// File: rtl/screen_fifo.sv
// Synchronous show-ahead FIFO (DEPTH x WIDTH) with flush.
// Ports: push/wr_dat in, pop out via rd_dat (head, valid when !empty), full/empty flags.
// A push while full is accepted only if a pop happens in the same cycle; flush wins over both.
module screen_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_dat  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/screen_frame_loader.sv
// CPU-side frame feeder for the 64x64 LED matrix driver: bus writes fill a FIFO,
// a START replays one NUM_PIXELS frame as init / wr_data+mat_in strobes.
// Ports: clk, reset (async active-low), cs/we/addr/d_in/d_out bus, mat_in/wr_data/init to driver.
// Optional GAMMA_LUT_EN: per-channel gamma on FIFO output, +1 cycle on mat_in/wr_data.
module screen_frame_loader
  import screen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic [31:0] mat_in,
  output logic        wr_data,
  output logic        init
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_done_q, frame_done_d;
  logic [31:0]          d_out_q, d_out_d;

  logic   wr_acc, rd_acc, start, clr, abort, push;
  logic   fifo_pop, fifo_full, fifo_empty, last_pop, done_set;
  pixel_t fifo_rd_dat;
  logic   unused_bits;

  assign wr_acc = cs && we;
  assign rd_acc = cs && !we;
  assign start  = wr_acc && (addr == REG_CTRL) && d_in[CTRL_START];
  assign clr    = wr_acc && (addr == REG_CTRL) && d_in[CTRL_CLR];
  assign abort  = wr_acc && (addr == REG_CTRL) && d_in[CTRL_ABORT];
  assign push   = wr_acc && (addr == REG_DATA) && !abort;
  assign unused_bits = ^d_in[31:TOTAL_BIT_DEPTH];

  screen_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TOTAL_BIT_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (fifo_pop),
    .flush  (abort),
    .wr_dat (d_in[TOTAL_BIT_DEPTH-1:0]),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_INIT;
      ST_INIT:   state_d = ST_GAP;
      ST_GAP:    state_d = ST_STREAM;
      ST_STREAM: if (last_pop) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // ---- FSM: outputs ----
  always_comb begin
    init     = (state_q == ST_INIT);
    // ABORT suppresses the pop so the count stays at pixels actually delivered
    fifo_pop = (state_q == ST_STREAM) && !fifo_empty && !abort;
    last_pop = fifo_pop && (count_q == COUNT_W'(NUM_PIXELS - 1));
  end

`ifdef GAMMA_LUT_EN
  logic        wr_data_q;
  logic [31:0] mat_in_q;
  logic        done_pend_q;

  // Extra stage; frame_done waits until the last corrected word has left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_data_q   <= 1'b0;
      mat_in_q    <= '0;
      done_pend_q <= 1'b0;
    end else begin
      wr_data_q   <= fifo_pop;
      mat_in_q    <= fifo_pop ? {20'b0, gamma_map(fifo_rd_dat)} : 32'b0;
      done_pend_q <= last_pop;
    end
  end

  assign wr_data  = wr_data_q;
  assign mat_in   = mat_in_q;
  assign done_set = done_pend_q;
`else
  assign wr_data  = fifo_pop;
  assign mat_in   = fifo_pop ? {20'b0, fifo_rd_dat} : 32'b0;
  assign done_set = last_pop;
`endif

  // ---- Counters, sticky flags, read mux ----
  always_comb begin
    count_d = count_q;
    if (state_q == ST_INIT) count_d = '0;
    else if (fifo_pop)      count_d = count_q + COUNT_W'(1);

    // Set beats CLR when both land in the same cycle
    frame_done_d = frame_done_q;
    if (done_set)  frame_done_d = 1'b1;
    else if (clr)  frame_done_d = 1'b0;

    overflow_d = overflow_q;
    if (push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    else if (clr)                       overflow_d = 1'b0;

    d_out_d = d_out_q;
    if (rd_acc) begin
      case (addr)
        REG_STATUS: d_out_d = {26'b0, overflow_q, frame_done_q, fifo_full, fifo_empty, state_q};
        REG_COUNT:  d_out_d = {{(32-COUNT_W){1'b0}}, count_q};
        default:    d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      d_out_q      <= '0;
    end else begin
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      d_out_q      <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_screen_frame_loader.sv
// Testbench for screen_frame_loader: randomized pixel traffic against a queue model,
// with a negedge monitor that checks every driver strobe.
module tb_screen_frame_loader;

  localparam int NPIX = 4096;
`ifdef GAMMA_LUT_EN
  localparam int LAT = 3;   // START edge -> init cycle -> gap -> pop -> registered strobe
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] d_in = 32'd0;
  logic [31:0] d_out, mat_in;
  logic        wr_data, init;

  screen_frame_loader dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .d_in(d_in),
    .d_out(d_out), .mat_in(mat_in), .wr_data(wr_data), .init(init)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];      // words the FIFO should hold / replay, in order
  int  frame_pulses = 0;
  int  init_pulses  = 0;
  int  cyc = 0, init_cyc = 0;
  bit  prev_init = 0, first_pending = 0, prompt = 0;

  function automatic void check(string name, longint act, longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endfunction

  // Expected driver word for a pushed pixel
  function automatic logic [11:0] expect_px(input logic [11:0] w);
`ifdef GAMMA_LUT_EN
    int lut [16];
    lut = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
    return {4'(lut[w[11:8]]), 4'(lut[w[7:4]]), 4'(lut[w[3:0]])};
`else
    return w;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      if (init) begin
        check("init_single_cycle", prev_init, 0);
        init_pulses++;
        init_cyc      = cyc;
        frame_pulses  = 0;
        first_pending = 1;
        prompt        = (exp_q.size() > 0);
      end
      if (wr_data) begin
        if (first_pending) begin
          if (prompt) check("first_strobe_latency", cyc - init_cyc, LAT);
          else        check("first_strobe_not_early", (cyc - init_cyc) >= LAT, 1);
          first_pending = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", mat_in, 32'hdead_beef);
        end else begin
          logic [11:0] w;
          w = exp_q.pop_front();
          check("mat_in", mat_in, {20'b0, expect_px(w)});
        end
        frame_pulses++;
      end
      prev_init = init;
    end else begin
      prev_init = 0;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; addr = a; d_in = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; d_in = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    d = d_out;
  endtask

  task automatic push_word(input logic [11:0] w, input bit accept);
    if (accept) exp_q.push_back(w);
    bus_write(2'd1, {20'b0, w});
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] expv);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, expv);
  endtask

  task automatic wait_frame_done();
    logic [31:0] s;
    int k;
    k = 0;
    do begin
      bus_read(2'd2, s);
      k++;
    end while (!s[4] && k < 2000);
    check("frame_done_seen", s[4], 1);
  endtask

  task automatic wait_pulses(input int n);
    int k;
    k = 0;
    while (frame_pulses < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check("pulse_wait", frame_pulses >= n, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ip;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", d_out, 0);
    check("rst_mat_in", mat_in, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_init", init, 0);
    @(negedge clk) reset = 1'b1;
    read_check("rst_status", 2'd2, 32'h04);
    read_check("rst_count", 2'd3, 32'h0);

    // 1: full frame of 0..4095, preloaded so the first strobe timing is exact
    for (int i = 0; i < 4; i++) push_word(12'(i), 1);
    bus_write(2'd0, 32'h1);
    for (int i = 4; i < NPIX; i++) push_word(12'(i), 1);
    wait_frame_done();
    read_check("t1_status", 2'd2, 32'h14);
    read_check("t1_count", 2'd3, NPIX);
    check("t1_pulses", frame_pulses, NPIX);
    check("t1_model_empty", exp_q.size(), 0);
    check("t1_init_pulses", init_pulses, 1);

    // 2: overflow without START; first 16 stay for the next frame
    for (int i = 0; i < 17; i++) push_word(12'($urandom), i < 16);
    read_check("t2_status_ovf", 2'd2, 32'h38);
    bus_write(2'd0, 32'h2);
    read_check("t2_status_clr", 2'd2, 32'h08);
    read_check("t2_ctrl_reads_0", 2'd0, 32'h0);
    read_check("t2_data_reads_0", 2'd1, 32'h0);

    // 3: leftovers + 10 words, long stall, rest of frame
    bus_write(2'd0, 32'h1);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) push_word(12'($urandom), 1);
    repeat (50) @(posedge clk);
    for (int i = 0; i < NPIX - 26; i++) push_word(12'($urandom), 1);
    wait_frame_done();
    read_check("t3_status", 2'd2, 32'h14);
    read_check("t3_count", 2'd3, NPIX);
    check("t3_pulses", frame_pulses, NPIX);
    check("t3_model_empty", exp_q.size(), 0);

    // 4: abort after 100 pixels, flush, restart
    bus_write(2'd0, 32'h3);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 100; i++) push_word(12'($urandom), 1);
    wait_pulses(100);
    repeat (3) @(posedge clk);
    bus_write(2'd0, 32'h4);
    read_check("t4_status_abort", 2'd2, 32'h04);
    read_check("t4_count_held", 2'd3, 100);
    for (int i = 0; i < 3; i++) push_word(12'($urandom), 1);
    bus_write(2'd0, 32'h4);
    exp_q.delete();
    read_check("t4_status_flushed", 2'd2, 32'h04);
    ip = init_pulses;
    bus_write(2'd0, 32'h1);
    repeat (3) @(posedge clk);
    check("t4_restart_init", init_pulses, ip + 1);
    read_check("t4_restart_count", 2'd3, 0);
    read_check("t4_status_stream", 2'd2, 32'h07);
    bus_write(2'd0, 32'h1);
    repeat (3) @(posedge clk);
    check("t4_start_ignored", init_pulses, ip + 1);

    // 5: reset mid-stream
    bus_write(2'd0, 32'h4);
    for (int i = 0; i < 8; i++) push_word(12'($urandom), 1);
    bus_write(2'd0, 32'h1);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (wr_data) found = 1;
    end
    check("t5_stream_seen", found, 1);
    #1 reset = 1'b0;
    #1;
    check("t5_wr_data", wr_data, 0);
    check("t5_init", init, 0);
    check("t5_mat_in", mat_in, 0);
    check("t5_d_out", d_out, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    read_check("t5_status", 2'd2, 32'h04);
    read_check("t5_count", 2'd3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
